// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data requests onto one fixed-latency RAM port.
// Under contention the grant alternates between the two streams (round-robin).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  localparam logic [3:0] LAT = 4'(RAM_LAT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;   // 1: most recent grant went to data
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;

  logic dpend;
  logic done;

  assign dpend = dREN | dWEN;
  assign done  = (cnt_q == 4'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        // Data wins when alone, or when both pend and instructions went last.
        if (dpend && (!iREN || !last_d_q)) begin
          state_d  = DACC;
          addr_d   = daddr;
          store_d  = dstore;
          wr_d     = dWEN;
          cnt_d    = LAT;
          last_d_d = 1'b1;
        end else if (iREN) begin
          state_d  = IACC;
          addr_d   = iaddr;
          wr_d     = 1'b0;
          cnt_d    = LAT;
          last_d_d = 1'b0;
        end
      end
      IACC, DACC: begin
        cnt_d = cnt_q - 4'd1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_REN   = 1'b0;
    ram_WEN   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    case (state_q)
      IACC: begin
        ram_REN  = 1'b1;
        ram_addr = addr_q;
        // A withdrawn request still finishes its RAM access, just without a hit.
        if (done && iREN) begin
          ihit  = 1'b1;
          iload = ram_load;
        end
      end
      DACC: begin
        ram_REN  = ~wr_q;
        ram_WEN  = wr_q;
        ram_addr = addr_q;
        if (wr_q) ram_store = store_q;
        if (done && dpend) begin
          dhit = 1'b1;
          if (!wr_q) dload = ram_load;
        end
      end
      default: ;
    endcase
  end

endmodule
